// File: rtl/gcd_stein.sv
// gcd_stein: multi-cycle binary (Stein) greatest-common-divisor engine.
//
// The engine uses only shift, compare and subtract operations. There is
// no divider. Operands are captured once, on an accepted start. The result
// is held from the done pulse until the next done-producing transition.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   resetn  - asynchronous active-low reset
//   opa     - operand A (unsigned), sampled on an accepted start
//   opb     - operand B (unsigned), sampled on an accepted start
//   start   - request; accepted on a rising edge with start=1 and busy=0
//   busy    - high while a computation is in progress (ALIGN/REDUCE)
//   done    - one-cycle pulse marking result valid
//   result  - gcd(opa, opb), held until the next done
module gcd_stein #(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIGN  = 2'd1,
    S_REDUCE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((opa == '0) || (opb == '0)) begin
            // gcd(x,0)=x and gcd(0,0)=0 both reduce to the OR of the operands.
            result_d = opa | opb;
            done_d   = 1'b1;
          end else begin
            a_d     = opa;
            b_d     = opb;
            k_d     = '0;
            state_d = S_ALIGN;
          end
        end
      end

      S_ALIGN: begin
        // Strip the common power of two. k remembers it for the final shift.
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = S_REDUCE;
        end
      end

      S_REDUCE: begin
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q == b_q) begin
          // The result never exceeds the original operands, so the shift cannot overflow.
          result_d = a_q << k_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/gcd_stein.md
Name: gcd_stein

Overview:
- Parametrised, multi-cycle greatest-common-divisor engine. It is the next generation of the team's `gcd` block.
- Uses the binary (Stein) algorithm: shift, compare and subtract only. No divider.
- Adds a WIDTH parameter, a busy indication, defined zero-operand results and back-to-back operation.
- Sits on a start/done handshake under a controlling FSM or testbench. Operands are sampled once; the result is held until the next accepted start.

Parameters:
- WIDTH, 32, operand and result width in bits (must be ≥ 2).
- KW, $clog2(WIDTH+1), width of the internal common-power-of-two counter k.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- opa  input  WIDTH  operand A, unsigned; sampled only on an accepted start.
- opb  input  WIDTH  operand B, unsigned; sampled only on an accepted start.
- start  input  1  request; accepted on a rising edge where start=1 and busy=0.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  gcd(opa,opb); held stable from done until the next accepted start.

Behaviour:
- Reset (resetn=0, asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0; internal a, b, k cleared.
  - Any in-flight computation is discarded; no done is produced for it.
- States: IDLE, ALIGN, REDUCE. busy=1 exactly in ALIGN and REDUCE.
- IDLE:
  - done defaults to 0 each cycle unless set by the rules below.
  - Accepted start with opa==0 or opb==0: state stays IDLE; next cycle done=1, result=opa|opb. Hence gcd(0,0)=0 and gcd(x,0)=x. Latency is 1 cycle.
  - Any other accepted start: a←opa, b←opb, k←0, state→ALIGN, result unchanged.
- ALIGN (one action per cycle):
  - If a[0]==0 and b[0]==0: a←a>>1, b←b>>1, k←k+1.
  - Otherwise: state→REDUCE.
- REDUCE (one action per cycle, evaluated in priority order):
  1. a[0]==0: a←a>>1.
  2. b[0]==0: b←b>>1.
  3. a==b: result←a<<k (WIDTH-bit, never overflows since the result ≤ the original operands), done←1, state→IDLE.
  4. a>b: a←a−b.
  5. Otherwise: b←b−a.
- Arithmetic rules: all unsigned WIDTH-bit. Subtraction occurs only when a≠b, both odd, and larger minus smaller, so it never underflows.
- Latency from accept to done ≤ 4*WIDTH+2 cycles for nonzero operands.
- done timing:
  - done is registered and asserted in the first IDLE cycle after REDUCE; busy=0 in that same cycle.
  - A start in the done cycle is accepted (back-to-back).
  - result changes only on done-producing transitions.
- start while busy=1 is ignored: no queueing, and operand changes have no effect.
- start held high continuously: a new computation is accepted each time the block reaches IDLE.
- Equal operands (opa==opb≠0): result=opa.
- Operands of 1: result=1.

Test Plan:
- Reset mid-run: start opa=1071, opb=462; drop resetn for 1 cycle after 5 cycles → busy=0, done=0, result=0 immediately; no done follows.
- Basic values, each checked with done pulsed exactly one cycle and within 4*WIDTH+2 cycles:
  - opa=1071, opb=462 → result=21.
  - opa=1075, opb=255 → result=5.
- Zero/identity cases: (0,0) → 0; (36,0) → 36; (0,7) → 7, each with done one cycle after start and busy never high. (1,0xFFFFFFFF) → 1.
- Power-of-two paths with WIDTH=32: (0x80000000,0x80000000) → 0x80000000; (96,64) → 32, exercising ALIGN with k=5.
- Handshake:
  - start re-pulsed with new operands while busy → ignored; result matches the original operands.
  - start asserted in the done cycle with (48,18) → accepted; next result=6.
- Parametrisation: WIDTH=8, exhaustive sweep of all 65 536 operand pairs against a reference model → all results match; latency never exceeds 34 cycles.
